// File: rtl/uart_alu_ctrl.sv
// Byte-stream front end for an external ALU: collects A, B and opcode bytes from
// the UART RX FIFO, registers the ALU result and pushes it into the UART TX FIFO.
module uart_alu_ctrl #(
    parameter int DBIT    = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx_empty,
    input  logic [DBIT-1:0] i_r_data,
    output logic            o_rd_uart,
    input  logic            i_tx_full,
    output logic            o_wr_uart,
    output logic [DBIT-1:0] o_w_data,
    output logic [DBIT-1:0] o_alu_a,
    output logic [DBIT-1:0] o_alu_b,
    output logic [OP_W-1:0] o_alu_op,
    input  logic [DBIT-1:0] i_alu_result,
    output logic            o_frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DBIT-1:0]   alu_a_q;
    logic [DBIT-1:0]   alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DBIT-1:0]   w_data_q;

    logic waiting;
    logic counting;
    logic rx_take;
    logic tx_put;
    logic timeout_hit;

    assign waiting     = (state_q == S_WAIT_A) || (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
    assign counting    = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
    assign rx_take     = waiting && !i_rx_empty;
    assign tx_put      = (state_q == S_SEND) && !i_tx_full;
    // An arriving byte wins over the timeout, so the error needs an empty FIFO.
    assign timeout_hit = counting && i_rx_empty && (cnt_q >= CNT_LIMIT);

    // Strobes are decoded from registered state so a FWFT byte is taken the
    // same cycle it is seen; reset masks them so nothing moves in that cycle.
    assign o_rd_uart   = rx_take && !i_reset;
    assign o_wr_uart   = tx_put && !i_reset;
    assign o_frame_err = timeout_hit && !i_reset;

    assign o_w_data = w_data_q;
    assign o_alu_a  = alu_a_q;
    assign o_alu_b  = alu_b_q;
    assign o_alu_op = alu_op_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_WAIT_A;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            w_data_q <= '0;
        end else begin
            case (state_q)
                S_WAIT_A: begin
                    cnt_q <= '0;
                    if (rx_take) begin
                        alu_a_q <= i_r_data;
                        state_q <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (rx_take) begin
                        alu_b_q <= i_r_data;
                        cnt_q   <= '0;
                        state_q <= S_WAIT_OP;
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_A;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_OP: begin
                    if (rx_take) begin
                        alu_op_q <= i_r_data[OP_W-1:0];
                        cnt_q    <= '0;
                        state_q  <= S_EXEC;
                    end else if (timeout_hit) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_A;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    w_data_q <= i_alu_result;
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    if (tx_put) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_A;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: FIFO model on the RX side, event log on
// the strobes, and frame-level expectations computed from the pushed bytes.
module tb_uart_alu_ctrl;

    localparam int DBIT    = 8;
    localparam int OP_W    = 6;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_rx_empty = 1'b1;
    logic [DBIT-1:0] i_r_data = '0;
    logic            i_tx_full = 1'b0;
    logic            o_rd_uart, o_wr_uart, o_frame_err;
    logic [DBIT-1:0] o_w_data, o_alu_a, o_alu_b, i_alu_result;
    logic [OP_W-1:0] o_alu_op;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    int overlap = 0;
    int rd_cyc[$];
    int wr_cyc[$];
    int err_cyc[$];
    logic [7:0] wr_dat[$];
    logic [7:0] rx_q[$];
    logic pop_pend = 1'b0;
    logic [5:0] op_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

    always #5 clk = ~clk;

    uart_alu_ctrl #(.DBIT(DBIT), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_r_data(i_r_data),
        .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart),
        .o_w_data(o_w_data), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .o_frame_err(o_frame_err)
    );

    // External ALU: ADD, SUB, AND, OR, XOR; unknown opcodes pass A through.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            default:   return a;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    always @(posedge clk) cyc <= cyc + 1;

    // Strobes are logged mid-cycle, tagged with the cycle they belong to.
    always @(negedge clk) begin
        pop_pend <= o_rd_uart;
        if (o_rd_uart) rd_cyc.push_back(cyc);
        if (o_wr_uart) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(o_w_data);
        end
        if (o_frame_err) err_cyc.push_back(cyc);
        if (o_rd_uart && o_wr_uart) overlap <= overlap + 1;
    end

    // First-word-fall-through RX FIFO: head popped after the edge that consumed it.
    always @(posedge clk) begin
        #2;
        if (pop_pend && rx_q.size() > 0) rx_q.delete(0);
        i_rx_empty <= (rx_q.size() == 0);
        i_r_data   <= (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(op);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_cyc.size() < n; i++) tick(1);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        tick(3);
        @(negedge clk);
        nvec++; if (o_rd_uart !== 1'b0) begin nmis++; $display("FAIL reset_rd: got %b want 0", o_rd_uart); end
        nvec++; if (o_wr_uart !== 1'b0) begin nmis++; $display("FAIL reset_wr: got %b want 0", o_wr_uart); end
        nvec++; if (o_frame_err !== 1'b0) begin nmis++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        nvec++; if (o_w_data !== 8'h00) begin nmis++; $display("FAIL reset_wdata: got %h want 00", o_w_data); end
        nvec++; if ({o_alu_a, o_alu_b} !== 16'h0000) begin nmis++; $display("FAIL reset_ab: got %h %h want 00 00", o_alu_a, o_alu_b); end
        nvec++; if (o_alu_op !== 6'd0) begin nmis++; $display("FAIL reset_op: got %b want 000000", o_alu_op); end
        @(posedge clk); #1;
        i_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_add;
        int r0, w0, lat;
        logic [7:0] got;
        r0 = rd_cyc.size(); w0 = wr_cyc.size();
        push_frame(8'h05, 8'h03, 8'h20);
        wait_writes(w0 + 1, 40);
        tick(4);
        got = (wr_dat.size() > w0) ? wr_dat[w0] : 8'hxx;
        lat = (wr_cyc.size() > w0 && rd_cyc.size() > r0 + 2) ? wr_cyc[w0] - rd_cyc[r0 + 2] : -1;
        nvec++; if (wr_cyc.size() !== w0 + 1) begin nmis++; $display("FAIL add_wr_count: got %0d want %0d", wr_cyc.size() - w0, 1); end
        nvec++; if (rd_cyc.size() !== r0 + 3) begin nmis++; $display("FAIL add_rd_count: got %0d want 3", rd_cyc.size() - r0); end
        nvec++; if (got !== 8'h08) begin nmis++; $display("FAIL add_data: got %h want 08", got); end
        nvec++; if (lat !== 2) begin nmis++; $display("FAIL add_latency: got %0d want 2", lat); end
        nvec++; if (o_alu_op !== 6'b100000) begin nmis++; $display("FAIL add_op: got %b want 100000", o_alu_op); end
        nvec++; if ({o_alu_a, o_alu_b} !== 16'h0503) begin nmis++; $display("FAIL add_operands: got %h %h want 05 03", o_alu_a, o_alu_b); end
    endtask

    task automatic test_sub_upper;
        int w0;
        logic [7:0] got;
        w0 = wr_cyc.size();
        push_frame(8'h0A, 8'h04, 8'hE2);
        wait_writes(w0 + 1, 40);
        tick(4);
        got = (wr_dat.size() > w0) ? wr_dat[w0] : 8'hxx;
        nvec++; if (o_alu_op !== 6'b100010) begin nmis++; $display("FAIL sub_op_mask: got %b want 100010", o_alu_op); end
        nvec++; if (got !== 8'h06) begin nmis++; $display("FAIL sub_data: got %h want 06", got); end
        nvec++; if (wr_cyc.size() !== w0 + 1) begin nmis++; $display("FAIL sub_wr_count: got %0d want 1", wr_cyc.size() - w0); end
    endtask

    task automatic test_tx_full;
        int w0, e0, r0, c_drop, c_got;
        logic [7:0] got;
        w0 = wr_cyc.size(); e0 = err_cyc.size(); r0 = rd_cyc.size();
        i_tx_full = 1'b1;
        push_frame(8'h33, 8'h11, 8'h24);
        tick(50);
        nvec++; if (wr_cyc.size() !== w0) begin nmis++; $display("FAIL full_no_write: got %0d writes want 0", wr_cyc.size() - w0); end
        nvec++; if (err_cyc.size() !== e0) begin nmis++; $display("FAIL full_no_err: got %0d errors want 0", err_cyc.size() - e0); end
        nvec++; if (rd_cyc.size() !== r0 + 3) begin nmis++; $display("FAIL full_rd_count: got %0d want 3", rd_cyc.size() - r0); end
        nvec++; if (o_w_data !== 8'h11) begin nmis++; $display("FAIL full_wdata_held: got %h want 11", o_w_data); end
        i_tx_full = 1'b0;
        c_drop = cyc;
        tick(4);
        got   = (wr_dat.size() > w0) ? wr_dat[w0] : 8'hxx;
        c_got = (wr_cyc.size() > w0) ? wr_cyc[w0] : -1;
        nvec++; if (wr_cyc.size() !== w0 + 1) begin nmis++; $display("FAIL full_release_count: got %0d want 1", wr_cyc.size() - w0); end
        nvec++; if (c_got !== c_drop) begin nmis++; $display("FAIL full_release_cycle: got %0d want %0d", c_got, c_drop); end
        nvec++; if (got !== 8'h11) begin nmis++; $display("FAIL full_release_data: got %h want 11", got); end
    endtask

    task automatic test_timeout;
        int r0, w0, e0, t_a, dt;
        logic [7:0] got;
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); e0 = err_cyc.size();
        rx_q.push_back(8'($urandom));
        for (int i = 0; i < 10 && rd_cyc.size() <= r0; i++) tick(1);
        t_a = (rd_cyc.size() > r0) ? rd_cyc[r0] : -1000;
        tick(30);
        dt = (err_cyc.size() > e0) ? err_cyc[e0] - t_a : -1;
        nvec++; if (err_cyc.size() !== e0 + 1) begin nmis++; $display("FAIL timeout_err_count: got %0d want 1", err_cyc.size() - e0); end
        nvec++; if (dt !== TIMEOUT) begin nmis++; $display("FAIL timeout_err_delay: got %0d want %0d", dt, TIMEOUT); end
        nvec++; if (wr_cyc.size() !== w0) begin nmis++; $display("FAIL timeout_no_write: got %0d want 0", wr_cyc.size() - w0); end
        push_frame(8'h01, 8'h02, 8'h20);
        wait_writes(w0 + 1, 40);
        tick(4);
        got = (wr_dat.size() > w0) ? wr_dat[w0] : 8'hxx;
        nvec++; if (got !== 8'h03) begin nmis++; $display("FAIL timeout_next_frame: got %h want 03", got); end
        nvec++; if (wr_cyc.size() !== w0 + 1) begin nmis++; $display("FAIL timeout_next_count: got %0d want 1", wr_cyc.size() - w0); end
    endtask

    task automatic test_reset_midframe;
        int r0, w0;
        logic [7:0] got;
        r0 = rd_cyc.size(); w0 = wr_cyc.size();
        rx_q.push_back(8'h77);
        rx_q.push_back(8'h55);
        for (int i = 0; i < 10 && rd_cyc.size() < r0 + 2; i++) tick(1);
        tick(1);
        i_reset = 1'b1;
        rx_q.push_back(8'h09);
        @(negedge clk);
        nvec++; if (o_rd_uart !== 1'b0) begin nmis++; $display("FAIL rst_mid_no_read: got %b want 0", o_rd_uart); end
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        nvec++; if ({o_alu_a, o_alu_b, o_w_data} !== 24'h000000) begin nmis++; $display("FAIL rst_mid_zero: got %h %h %h want 00 00 00", o_alu_a, o_alu_b, o_w_data); end
        nvec++; if (o_alu_op !== 6'd0) begin nmis++; $display("FAIL rst_mid_op_zero: got %b want 000000", o_alu_op); end
        @(posedge clk); #1;
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h25);
        wait_writes(w0 + 1, 40);
        tick(4);
        got = (wr_dat.size() > w0) ? wr_dat[w0] : 8'hxx;
        nvec++; if (got !== 8'h0B) begin nmis++; $display("FAIL rst_mid_result: got %h want 0b", got); end
        nvec++; if (wr_cyc.size() !== w0 + 1) begin nmis++; $display("FAIL rst_mid_wr_count: got %0d want 1", wr_cyc.size() - w0); end
        nvec++; if (rd_cyc.size() !== r0 + 5) begin nmis++; $display("FAIL rst_mid_rd_count: got %0d want 5", rd_cyc.size() - r0); end
    endtask

    task automatic test_back_to_back;
        int r0, w0, ov0;
        logic [7:0] a, b, op, exp_q[$], got;
        r0 = rd_cyc.size(); w0 = wr_cyc.size(); ov0 = overlap;
        for (int f = 0; f < 4; f++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = {2'($urandom), op_tab[$urandom_range(0, 4)]};
            push_frame(a, b, op);
            exp_q.push_back(alu_ref(a, b, op[5:0]));
        end
        wait_writes(w0 + 4, 100);
        tick(4);
        nvec++; if (rd_cyc.size() !== r0 + 12) begin nmis++; $display("FAIL b2b_rd_count: got %0d want 12", rd_cyc.size() - r0); end
        nvec++; if (wr_cyc.size() !== w0 + 4) begin nmis++; $display("FAIL b2b_wr_count: got %0d want 4", wr_cyc.size() - w0); end
        nvec++; if (overlap !== ov0) begin nmis++; $display("FAIL b2b_overlap: got %0d want 0", overlap - ov0); end
        for (int f = 0; f < 4; f++) begin
            got = (wr_dat.size() > w0 + f) ? wr_dat[w0 + f] : 8'hxx;
            nvec++; if (got !== exp_q[f]) begin nmis++; $display("FAIL b2b_result[%0d]: got %h want %h", f, got, exp_q[f]); end
        end
    endtask

    task automatic test_random;
        int w0, e0, ov0;
        logic [7:0] a, b, op, exp_v, got;
        w0 = wr_cyc.size(); e0 = err_cyc.size(); ov0 = overlap;
        for (int f = 0; f < 16; f++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'($urandom), op_tab[$urandom_range(0, 4)]};
            exp_v = alu_ref(a, b, op[5:0]);
            // Gaps between bytes stay well below the timeout.
            rx_q.push_back(a);
            tick($urandom_range(1, 8));
            rx_q.push_back(b);
            tick($urandom_range(1, 8));
            rx_q.push_back(op);
            for (int i = 0; i < 60 && wr_cyc.size() < w0 + f + 1; i++) begin
                tick(1);
                i_tx_full = ($urandom_range(0, 2) == 0);
            end
            i_tx_full = 1'b0;
            got = (wr_dat.size() > w0 + f) ? wr_dat[w0 + f] : 8'hxx;
            nvec++; if (got !== exp_v) begin nmis++; $display("FAIL rand_result[%0d]: got %h want %h (a=%h b=%h op=%h)", f, got, exp_v, a, b, op); end
        end
        tick(4);
        nvec++; if (wr_cyc.size() !== w0 + 16) begin nmis++; $display("FAIL rand_wr_count: got %0d want 16", wr_cyc.size() - w0); end
        nvec++; if (err_cyc.size() !== e0) begin nmis++; $display("FAIL rand_no_err: got %0d want 0", err_cyc.size() - e0); end
        nvec++; if (overlap !== ov0) begin nmis++; $display("FAIL rand_overlap: got %0d want 0", overlap - ov0); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_upper;
        test_tx_full;
        test_timeout;
        test_reset_midframe;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
